// File: rtl/mul_div_unit_if.sv
// Handshake/result bundle between the datapath and mul_div_unit.
// The datapath uses the master view and mul_div_unit uses the slave view.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] zhi;
  logic [WIDTH-1:0] zlo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, zhi, zlo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, zhi, zlo, div_by_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (Booth) / divide (restoring) unit feeding ZHI/ZLO.
// Define MULDIV_BOOTH_R4_EN to use radix-4 Booth for MUL; DIV is the same in both builds.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           clr,
  mul_div_unit_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef MULDIV_BOOTH_R4_EN
  localparam int unsigned MUL_STEPS = WIDTH / 2;
`else
  localparam int unsigned MUL_STEPS = WIDTH;
`endif
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STEPS);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

  logic [2:0]       state_q, state_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH+1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             g_q, g_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] zhi_q, zhi_d;
  logic [WIDTH-1:0] zlo_q, zlo_d;
  logic             flag_q, flag_d;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH+1:0] mc_ext, pp, hi_sum;
  logic [WIDTH+1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic             mul_g;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             qbit;
  logic [WIDTH+1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic [CW-1:0]    run_last;

  assign a_abs  = a_q[WIDTH-1] ? -a_q : a_q;
  assign b_abs  = b_q[WIDTH-1] ? -b_q : b_q;
  assign mc_ext = {{2{mcand_q[WIDTH-1]}}, mcand_q};

  // Booth step: {hi, lo, guard} forms one arithmetic shift register.
  always_comb begin
    pp = '0;
`ifdef MULDIV_BOOTH_R4_EN
    case ({lo_q[1:0], g_q})
      3'b001, 3'b010: pp = mc_ext;
      3'b011:         pp = mc_ext << 1;
      3'b100:         pp = -(mc_ext << 1);
      3'b101, 3'b110: pp = -mc_ext;
      default:        pp = '0;
    endcase
    hi_sum = hi_q + pp;
    mul_hi = {{2{hi_sum[WIDTH+1]}}, hi_sum[WIDTH+1:2]};
    mul_lo = {hi_sum[1:0], lo_q[WIDTH-1:2]};
    mul_g  = lo_q[1];
`else
    case ({lo_q[0], g_q})
      2'b01:   pp = mc_ext;
      2'b10:   pp = -mc_ext;
      default: pp = '0;
    endcase
    hi_sum = hi_q + pp;
    mul_hi = {hi_sum[WIDTH+1], hi_sum[WIDTH+1:1]};
    mul_lo = {hi_sum[0], lo_q[WIDTH-1:1]};
    mul_g  = lo_q[0];
`endif
  end

  // Restoring step: dividend shifts out of lo while quotient bits shift in.
  assign rem_sh  = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, mcand_q};
  assign qbit    = (rem_sh >= {1'b0, mcand_q});
  assign div_hi  = {1'b0, (qbit ? rem_sub : rem_sh)};
  assign div_lo  = {lo_q[WIDTH-2:0], qbit};

  always_comb begin
    if (!op_q) begin
      fix_hi = hi_q[WIDTH-1:0];
      fix_lo = lo_q;
    end else if (dbz_q) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else begin
      fix_hi = negr_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
      fix_lo = negq_q ? -lo_q : lo_q;
    end
  end

  assign run_last = op_q ? DIV_LAST : MUL_LAST;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dbz_d   = dbz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    zhi_d   = zhi_q;
    zlo_d   = zlo_q;
    flag_d  = flag_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d = '0;
        hi_d  = '0;
        g_d   = 1'b0;
        if (op_q) begin
          lo_d    = a_abs;
          mcand_d = b_abs;
          negq_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
          negr_d  = a_q[WIDTH-1];
          dbz_d   = (b_q == '0);
        end else begin
          lo_d    = b_q;
          mcand_d = a_q;
          negq_d  = 1'b0;
          negr_d  = 1'b0;
          dbz_d   = 1'b0;
        end
        state_d = S_RUN;
      end
      S_RUN: begin
        // One edge beyond the last iteration is spent here so FIX lands on E+WIDTH+2.
        if (cnt_q == run_last) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (op_q) begin
            hi_d = div_hi;
            lo_d = div_lo;
          end else begin
            hi_d = mul_hi;
            lo_d = mul_lo;
            g_d  = mul_g;
          end
        end
      end
      S_FIX: begin
        zhi_d   = fix_hi;
        zlo_d   = fix_lo;
        flag_d  = op_q & dbz_q;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      g_q     <= 1'b0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
      flag_q  <= flag_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.zhi         = zhi_q;
  assign bus.zlo         = zlo_q;
  assign bus.div_by_zero = flag_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (results, latency, busy/done, clr, start filtering).
module tb_mul_div_unit;

  localparam int W = 32;
`ifdef MULDIV_BOOTH_R4_EN
  localparam int MUL_LAT = W / 2 + 3;
`else
  localparam int MUL_LAT = W + 3;
`endif
  localparam int DIV_LAT = W + 3;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus_if ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] r_hi, r_lo;
  logic        r_dbz;
  logic        r_busy_first, r_busy_at_done, r_busy_after;
  int          r_lat, r_pulses;

  // Issues one operation and records what the DUT shows; edge index j = edges after accept E.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, input int inj_k);
    r_lat = -1; r_pulses = 0; r_busy_first = 1'b0; r_busy_at_done = 1'b0; r_busy_after = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = o; bus_if.a = x; bus_if.b = y;
    @(posedge clk);
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (k == 1) begin
        r_busy_first = bus_if.busy;
        bus_if.a = ~x; bus_if.b = x ^ y; bus_if.op = ~o;
      end
      bus_if.start = (k == inj_k);
      if (bus_if.done) begin
        if (r_lat < 0) begin
          r_lat = k - 1;
          r_busy_at_done = bus_if.busy;
        end
        r_pulses++;
      end else if (r_lat >= 0) begin
        r_busy_after = bus_if.busy;
        break;
      end
    end
    bus_if.start = 1'b0;
    r_hi = bus_if.zhi; r_lo = bus_if.zlo; r_dbz = bus_if.div_by_zero;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus_if.start = 1'b0; bus_if.op = 1'b0; bus_if.a = '0; bus_if.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", bus_if.busy); end
    n_cmp++; if (bus_if.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", bus_if.done); end
    n_cmp++; if (bus_if.zhi !== 32'h0) begin n_bad++; $display("FAIL reset_zhi got=%h want=0", bus_if.zhi); end
    n_cmp++; if (bus_if.zlo !== 32'h0) begin n_bad++; $display("FAIL reset_zlo got=%h want=0", bus_if.zlo); end
    n_cmp++; if (bus_if.div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dbz got=%b want=0", bus_if.div_by_zero); end
    clr = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] ta [0:4];
    logic [31:0] tb [0:4];
    logic [31:0] eh [0:4];
    logic [31:0] el [0:4];
    ta = '{32'd7,         32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    tb = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0001_2345};
    eh = '{32'hFFFF_FFFF, 32'h4000_0000, 32'h3FFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    el = '{32'hFFFF_FFEB, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000};
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, ta[i], tb[i], 0);
      n_cmp++; if (r_hi !== eh[i]) begin n_bad++; $display("FAIL mul%0d_zhi got=%h want=%h", i, r_hi, eh[i]); end
      n_cmp++; if (r_lo !== el[i]) begin n_bad++; $display("FAIL mul%0d_zlo got=%h want=%h", i, r_lo, el[i]); end
      n_cmp++; if (r_dbz !== 1'b0) begin n_bad++; $display("FAIL mul%0d_dbz got=%b want=0", i, r_dbz); end
      n_cmp++; if (r_lat !== MUL_LAT) begin n_bad++; $display("FAIL mul%0d_latency got=%0d want=%0d", i, r_lat, MUL_LAT); end
      n_cmp++; if (r_pulses !== 1) begin n_bad++; $display("FAIL mul%0d_done_width got=%0d want=1", i, r_pulses); end
      if (i == 0) begin
        n_cmp++; if (r_busy_first !== 1'b1) begin n_bad++; $display("FAIL mul_busy_after_E got=%b want=1", r_busy_first); end
        n_cmp++; if (r_busy_at_done !== 1'b1) begin n_bad++; $display("FAIL mul_busy_with_done got=%b want=1", r_busy_at_done); end
        n_cmp++; if (r_busy_after !== 1'b0) begin n_bad++; $display("FAIL mul_busy_after_done got=%b want=0", r_busy_after); end
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] ta [0:3];
    logic [31:0] tb [0:3];
    logic [31:0] eh [0:3];
    logic [31:0] el [0:3];
    ta = '{32'hFFFF_FFF9, 32'd7,         32'd100,       32'h8000_0000};
    tb = '{32'd2,         32'hFFFF_FFFE, 32'd7,         32'hFFFF_FFFF};
    eh = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000};
    el = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h0000_000E, 32'h8000_0000};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, ta[i], tb[i], 0);
      n_cmp++; if (r_hi !== eh[i]) begin n_bad++; $display("FAIL div%0d_zhi got=%h want=%h", i, r_hi, eh[i]); end
      n_cmp++; if (r_lo !== el[i]) begin n_bad++; $display("FAIL div%0d_zlo got=%h want=%h", i, r_lo, el[i]); end
      n_cmp++; if (r_dbz !== 1'b0) begin n_bad++; $display("FAIL div%0d_dbz got=%b want=0", i, r_dbz); end
      n_cmp++; if (r_lat !== DIV_LAT) begin n_bad++; $display("FAIL div%0d_latency got=%0d want=%0d", i, r_lat, DIV_LAT); end
      n_cmp++; if (r_pulses !== 1) begin n_bad++; $display("FAIL div%0d_done_width got=%0d want=1", i, r_pulses); end
    end
  endtask

  task automatic test_div_by_zero();
    run_op(1'b1, 32'h1234_5678, 32'h0, 0);
    n_cmp++; if (r_dbz !== 1'b1) begin n_bad++; $display("FAIL dbz_flag got=%b want=1", r_dbz); end
    n_cmp++; if (r_lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dbz_zlo got=%h want=ffffffff", r_lo); end
    n_cmp++; if (r_hi !== 32'h1234_5678) begin n_bad++; $display("FAIL dbz_zhi got=%h want=12345678", r_hi); end
    n_cmp++; if (r_lat !== DIV_LAT) begin n_bad++; $display("FAIL dbz_latency got=%0d want=%0d", r_lat, DIV_LAT); end
    run_op(1'b1, 32'hFFFF_FFF9, 32'h0, 0);
    n_cmp++; if (r_hi !== 32'hFFFF_FFF9) begin n_bad++; $display("FAIL dbz_neg_zhi got=%h want=fffffff9", r_hi); end
    n_cmp++; if (r_dbz !== 1'b1) begin n_bad++; $display("FAIL dbz_neg_flag got=%b want=1", r_dbz); end
    run_op(1'b0, 32'd3, 32'd5, 0);
    n_cmp++; if (r_dbz !== 1'b0) begin n_bad++; $display("FAIL dbz_cleared_by_mul got=%b want=0", r_dbz); end
    n_cmp++; if (r_lo !== 32'd15) begin n_bad++; $display("FAIL mul_after_dbz_zlo got=%h want=0000000f", r_lo); end
  endtask

  task automatic test_control();
    int seen_done;
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 5);
    n_cmp++; if (r_hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL busy_start_zhi got=%h want=ffffffff", r_hi); end
    n_cmp++; if (r_lo !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL busy_start_zlo got=%h want=ffffffeb", r_lo); end
    n_cmp++; if (r_lat !== MUL_LAT) begin n_bad++; $display("FAIL busy_start_latency got=%0d want=%0d", r_lat, MUL_LAT); end
    n_cmp++; if (r_pulses !== 1) begin n_bad++; $display("FAIL busy_start_done_width got=%0d want=1", r_pulses); end

    seen_done = 0;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = 1'b1; bus_if.a = 32'd100; bus_if.b = 32'd7;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
      if (k > 11 && bus_if.done) seen_done++;
      if (k == 10) clr = 1'b1;
      if (k == 11) begin
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_bad++; $display("FAIL clr_busy got=%b want=0", bus_if.busy); end
        n_cmp++; if (bus_if.done !== 1'b0) begin n_bad++; $display("FAIL clr_done got=%b want=0", bus_if.done); end
        n_cmp++; if (bus_if.zhi !== 32'h0) begin n_bad++; $display("FAIL clr_zhi got=%h want=0", bus_if.zhi); end
        n_cmp++; if (bus_if.zlo !== 32'h0) begin n_bad++; $display("FAIL clr_zlo got=%h want=0", bus_if.zlo); end
        clr = 1'b0;
      end
    end
    n_cmp++; if (seen_done !== 0) begin n_bad++; $display("FAIL clr_no_done got=%0d want=0", seen_done); end
  endtask

  task automatic test_back_to_back();
    int d_at;
    int lat2;
    d_at = -1;
    lat2 = -1;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = 1'b0; bus_if.a = 32'd6; bus_if.b = 32'd9;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
      if (bus_if.done) begin d_at = k - 1; break; end
    end
    n_cmp++; if (d_at !== MUL_LAT) begin n_bad++; $display("FAIL b2b_first_latency got=%0d want=%0d", d_at, MUL_LAT); end
    n_cmp++; if (bus_if.zlo !== 32'd54) begin n_bad++; $display("FAIL b2b_first_zlo got=%h want=00000036", bus_if.zlo); end
    // start raised in the done cycle and held: only the following edge may accept it
    bus_if.start = 1'b1; bus_if.op = 1'b1; bus_if.a = 32'hFFFF_FFF9; bus_if.b = 32'd2;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_done_cycle_start_ignored busy=%b want=0", bus_if.busy); end
      end
      if (k == 2) bus_if.start = 1'b0;
      if (bus_if.done) begin lat2 = k - 2; break; end
    end
    n_cmp++; if (lat2 !== DIV_LAT) begin n_bad++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat2, DIV_LAT); end
    n_cmp++; if (bus_if.zlo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL b2b_second_zlo got=%h want=fffffffd", bus_if.zlo); end
    n_cmp++; if (bus_if.zhi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL b2b_second_zhi got=%h want=ffffffff", bus_if.zhi); end
    bus_if.start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_control();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
